// File: rtl/sd_sector_responder_pkg.sv
// Shared state encoding and sector constants for the backup-RAM sector responder.
package sd_sector_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    RD_PUSH  = 3'd3,
    WR_ADDR  = 3'd4,
    WR_LAT   = 3'd5,
    WR_WAIT  = 3'd6,
    DONE     = 3'd7
  } state_t;

  localparam int          SECTOR_WORDS = 256;
  localparam logic [15:0] OOR_FILL     = 16'hFFFF;
  localparam logic [7:0]  LAST_IDX     = 8'(SECTOR_WORDS - 1);

endpackage

// File: rtl/sd_sector_responder_toggle_req.sv
// Toggle-style requester: flips req once per request, pending while req and ack differ.
module toggle_req (
  input  logic clk,
  input  logic rst_n,
  input  logic i_fire,
  input  logic i_ack,
  output logic o_req,
  output logic o_pending
);

  logic r_req;
  logic w_pending;

  assign w_pending = r_req ^ i_ack;

  // A new toggle is refused while the previous one is still unacknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req <= 1'b0;
    end else if (i_fire && !w_pending) begin
      r_req <= ~r_req;
    end else begin
      r_req <= r_req;
    end
  end

  assign o_req     = r_req;
  assign o_pending = w_pending;

endmodule

// File: rtl/sd_sector_responder.sv
// Sector responder: moves 256-word sectors between the sd_buff interface and a
// word-addressed DDRAM port using toggle req/ack handshakes.
module sd_sector_responder
  import sd_sector_pkg::*;
#(
  parameter int unsigned LBA_W      = 7,
  parameter logic [23:0] BASE_WADDR = 24'h7F0000,
  parameter int unsigned BUF_LAT    = 1
) (
  input  logic        clk_sys,
  input  logic        RESET_N,
  input  logic [31:0] sd_lba,
  input  logic        sd_rd,
  input  logic        sd_wr,
  output logic        sd_ack,
  output logic [7:0]  sd_buff_addr,
  output logic [15:0] sd_buff_dout,
  input  logic [15:0] sd_buff_din,
  output logic        sd_buff_wr,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_din,
  output logic        mem_we_req,
  input  logic        mem_we_ack,
  input  logic [15:0] mem_dout,
  output logic        mem_rd_req,
  input  logic        mem_rd_ack,
  output logic        busy
);

  state_t             r_state;
  logic [LBA_W-1:0]   r_lba;
  logic               r_oor;
  logic [7:0]         r_idx;
  logic [7:0]         r_lat;
  logic               r_ack;
  logic               r_busy;
  logic [7:0]         r_buff_addr;
  logic [15:0]        r_buff_dout;
  logic               r_buff_wr;
  logic [23:0]        r_mem_addr;
  logic [15:0]        r_mem_din;

  logic               w_rd_fire;
  logic               w_we_fire;
  logic               w_rd_pend;
  logic               w_we_pend;
  logic               w_lat_done;
  logic               w_last;
  logic [23:0]        w_waddr;

  // {lba, idx} is zero-extended before the add, so the result wraps modulo 2^24.
  assign w_waddr    = BASE_WADDR + 24'({r_lba, r_idx});
  assign w_last     = (r_idx == LAST_IDX);
  assign w_lat_done = ({24'd0, r_lat} >= 32'(BUF_LAT));
  assign w_rd_fire  = (r_state == RD_ISSUE) && !r_oor;
  assign w_we_fire  = (r_state == WR_LAT) && w_lat_done && !r_oor;

  toggle_req u_rd_req (
    .clk       (clk_sys),
    .rst_n     (RESET_N),
    .i_fire    (w_rd_fire),
    .i_ack     (mem_rd_ack),
    .o_req     (mem_rd_req),
    .o_pending (w_rd_pend)
  );

  toggle_req u_we_req (
    .clk       (clk_sys),
    .rst_n     (RESET_N),
    .i_fire    (w_we_fire),
    .i_ack     (mem_we_ack),
    .o_req     (mem_we_req),
    .o_pending (w_we_pend)
  );

  // Sector transfer sequencer with registered interface outputs.
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= IDLE;
      r_lba       <= '0;
      r_oor       <= 1'b0;
      r_idx       <= 8'd0;
      r_lat       <= 8'd0;
      r_ack       <= 1'b0;
      r_busy      <= 1'b0;
      r_buff_addr <= 8'd0;
      r_buff_dout <= 16'd0;
      r_buff_wr   <= 1'b0;
      r_mem_addr  <= 24'd0;
      r_mem_din   <= 16'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (sd_rd || sd_wr) begin
            r_lba       <= sd_lba[LBA_W-1:0];
            r_oor       <= |sd_lba[31:LBA_W];
            r_idx       <= 8'd0;
            r_buff_addr <= 8'd0;
            r_ack       <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= sd_rd ? RD_ISSUE : WR_ADDR;
          end else begin
            r_state <= IDLE;
          end
        end
        RD_ISSUE: begin
          if (r_oor) begin
            r_buff_addr <= r_idx;
            r_buff_dout <= OOR_FILL;
            r_buff_wr   <= 1'b1;
            r_state     <= RD_PUSH;
          end else begin
            r_mem_addr <= w_waddr;
            r_state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (!w_rd_pend) begin
            r_buff_addr <= r_idx;
            r_buff_dout <= mem_dout;
            r_buff_wr   <= 1'b1;
            r_state     <= RD_PUSH;
          end else begin
            r_state <= RD_WAIT;
          end
        end
        RD_PUSH: begin
          r_buff_wr <= 1'b0;
          if (w_last) begin
            r_state <= DONE;
          end else begin
            r_idx   <= r_idx + 8'd1;
            r_state <= RD_ISSUE;
          end
        end
        WR_ADDR: begin
          r_lat   <= 8'd1;
          r_state <= WR_LAT;
        end
        WR_LAT: begin
          if (w_lat_done) begin
            if (!r_oor) begin
              r_mem_addr <= w_waddr;
              r_mem_din  <= sd_buff_din;
            end else begin
              r_mem_din  <= r_mem_din;
            end
            r_state <= WR_WAIT;
          end else begin
            r_lat <= r_lat + 8'd1;
          end
        end
        WR_WAIT: begin
          // Out-of-range writes never toggled, so they fall straight through here.
          if (!w_we_pend) begin
            if (w_last) begin
              r_state <= DONE;
            end else begin
              r_idx       <= r_idx + 8'd1;
              r_buff_addr <= r_idx + 8'd1;
              r_state     <= WR_ADDR;
            end
          end else begin
            r_state <= WR_WAIT;
          end
        end
        DONE: begin
          r_ack   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign sd_ack       = r_ack;
  assign busy         = r_busy;
  assign sd_buff_addr = r_buff_addr;
  assign sd_buff_dout = r_buff_dout;
  assign sd_buff_wr   = r_buff_wr;
  assign mem_addr     = r_mem_addr;
  assign mem_din      = r_mem_din;

endmodule

// File: tb/tb_sd_sector_responder.sv
// Scoreboard bench for sd_sector_responder: stimulus queues expected strobes and
// memory toggles, a negedge monitor pops and compares them as the DUT emits them.
module tb_sd_sector_responder;

  localparam logic [23:0] BASE = 24'h7F0000;

  logic        clk_sys = 1'b0;
  logic        RESET_N;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout;
  logic [15:0] sd_buff_din;
  logic        sd_buff_wr;
  logic [23:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_we_req;
  logic        mem_we_ack;
  logic [15:0] mem_dout;
  logic        mem_rd_req;
  logic        mem_rd_ack;
  logic        busy;

  always #5 clk_sys = ~clk_sys;

  sd_sector_responder #(
    .LBA_W      (7),
    .BASE_WADDR (BASE),
    .BUF_LAT    (1)
  ) dut (
    .clk_sys      (clk_sys),
    .RESET_N      (RESET_N),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_din  (sd_buff_din),
    .sd_buff_wr   (sd_buff_wr),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_we_req   (mem_we_req),
    .mem_we_ack   (mem_we_ack),
    .mem_dout     (mem_dout),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_ack   (mem_rd_ack),
    .busy         (busy)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_strobe_cyc = 0;
  int          we_seen = 0;
  int unsigned dly_max = 0;
  int unsigned rd_cnt;
  int unsigned we_cnt;

  logic [23:0] exp_buf[$];
  logic [23:0] exp_rd[$];
  logic [39:0] exp_we[$];

  logic prev_rd_req, prev_rd_ack, prev_we_req, prev_we_ack;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Sector buffer: registered read, one cycle after the address, data = ~addr.
  always @(posedge clk_sys) sd_buff_din <= ~{8'd0, sd_buff_addr};

  // DDRAM model: acks each toggle after a random 0..dly_max cycle delay; reads return addr[15:0].
  always @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      mem_rd_ack <= 1'b0;
      mem_we_ack <= 1'b0;
      mem_dout   <= 16'd0;
      rd_cnt     <= 0;
      we_cnt     <= 0;
    end else begin
      if (mem_rd_req != mem_rd_ack) begin
        if (rd_cnt == 0) begin
          mem_rd_ack <= mem_rd_req;
          mem_dout   <= mem_addr[15:0];
          rd_cnt     <= $urandom_range(dly_max, 0);
        end else begin
          rd_cnt <= rd_cnt - 1;
        end
      end
      if (mem_we_req != mem_we_ack) begin
        if (we_cnt == 0) begin
          mem_we_ack <= mem_we_req;
          we_cnt     <= $urandom_range(dly_max, 0);
        end else begin
          we_cnt <= we_cnt - 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic missing(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: DUT event with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes the buffer or toggles a request.
  initial begin
    prev_rd_req = 1'b0;
    prev_rd_ack = 1'b0;
    prev_we_req = 1'b0;
    prev_we_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (RESET_N) begin
        if (sd_buff_wr) begin
          last_strobe_cyc = cyc;
          if (exp_buf.size() == 0) missing("buf_strobe");
          else check("buf_word", 64'({sd_buff_addr, sd_buff_dout}), 64'(exp_buf.pop_front()));
        end
        if (mem_rd_req != prev_rd_req) begin
          check("rd_outstanding", 64'(prev_rd_req ^ prev_rd_ack), 64'd0);
          if (exp_rd.size() == 0) missing("rd_toggle");
          else check("rd_addr", 64'(mem_addr), 64'(exp_rd.pop_front()));
        end
        if (mem_we_req != prev_we_req) begin
          we_seen++;
          check("we_outstanding", 64'(prev_we_req ^ prev_we_ack), 64'd0);
          if (exp_we.size() == 0) missing("we_toggle");
          else check("we_addr_din", 64'({mem_addr, mem_din}), 64'(exp_we.pop_front()));
        end
      end
      prev_rd_req = mem_rd_req;
      prev_rd_ack = mem_rd_ack;
      prev_we_req = mem_we_req;
      prev_we_ack = mem_we_ack;
    end
  end

  function automatic void push_exp(input bit is_rd, input logic [31:0] lba);
    bit          oor;
    logic [23:0] a;
    oor = (lba[31:7] != 25'd0);
    for (int i = 0; i < 256; i++) begin
      a = BASE + (24'(lba[6:0]) << 8) + 24'(i);
      if (is_rd) begin
        if (oor) begin
          exp_buf.push_back({8'(i), 16'hFFFF});
        end else begin
          exp_rd.push_back(a);
          exp_buf.push_back({8'(i), a[15:0]});
        end
      end else if (!oor) begin
        exp_we.push_back({a, ~16'(i)});
      end
    end
  endfunction

  task automatic do_xfer(input bit is_rd, input bit both, input bit imm, input logic [31:0] lba);
    bit done;
    push_exp(is_rd, lba);
    if (!imm) @(negedge clk_sys);
    sd_lba = lba;
    sd_rd  = is_rd | both;
    sd_wr  = ~is_rd | both;
    @(posedge clk_sys);
    #1;
    check("ack_rise", 64'(sd_ack), 64'd1);
    check("busy_rise", 64'(busy), 64'd1);
    sd_rd  = 1'b0;
    sd_wr  = 1'b0;
    sd_lba = 32'hDEAD_BEEF;
    done = 1'b0;
    for (int t = 0; t < 12000 && !done; t++) begin
      @(negedge clk_sys);
      #1;
      if (!sd_ack) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL xfer_timeout: sd_ack still %b, required 0 (lba %h)", sd_ack, lba);
    end else begin
      check("busy_fall", 64'(busy), 64'd0);
      if (is_rd) check("ack_fall_delay", 64'(cyc - last_strobe_cyc), 64'd2);
    end
    check("queues_drained", 64'(exp_buf.size() + exp_rd.size() + exp_we.size()), 64'd0);
    exp_buf.delete();
    exp_rd.delete();
    exp_we.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required $finish first");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit          hit;
    int          we_base;
    logic [31:0] lba;
    RESET_N = 1'b1;
    sd_lba  = 32'd0;
    sd_rd   = 1'b0;
    sd_wr   = 1'b0;
    #2;
    RESET_N = 1'b0;
    #1;
    check("rst_ctrl", 64'({sd_ack, busy, sd_buff_wr, mem_rd_req, mem_we_req}), 64'd0);
    check("rst_buff", 64'({sd_buff_addr, sd_buff_dout}), 64'd0);
    check("rst_mem", 64'({mem_addr, mem_din}), 64'd0);
    repeat (4) @(negedge clk_sys);
    RESET_N = 1'b1;
    repeat (2) @(negedge clk_sys);

    do_xfer(1'b1, 1'b0, 1'b0, 32'd3);
    do_xfer(1'b0, 1'b0, 1'b0, 32'd0);
    do_xfer(1'b1, 1'b0, 1'b0, 32'd200);
    do_xfer(1'b0, 1'b0, 1'b0, 32'h0000_0080);
    do_xfer(1'b1, 1'b1, 1'b0, 32'd33);

    // Back-to-back sectors, each re-requested the cycle sd_ack falls.
    for (int k = 0; k < 32; k++) begin
      lba = 32'((k * 127) / 31);
      do_xfer((k % 2) == 0, 1'b0, 1'b1, lba);
    end

    dly_max = 20;
    do_xfer(1'b1, 1'b0, 1'b0, 32'd77);
    do_xfer(1'b0, 1'b0, 1'b0, 32'd78);
    dly_max = 0;

    // Write interrupted by reset right after the word-100 toggle.
    push_exp(1'b0, 32'd5);
    we_base = we_seen;
    @(negedge clk_sys);
    sd_lba = 32'd5;
    sd_wr  = 1'b1;
    @(posedge clk_sys);
    #1;
    sd_wr = 1'b0;
    hit = 1'b0;
    for (int t = 0; t < 3000 && !hit; t++) begin
      @(negedge clk_sys);
      #1;
      if (we_seen - we_base >= 101) hit = 1'b1;
    end
    if (!hit) begin
      n_cmp++;
      n_err++;
      $display("FAIL reset_wait: saw %0d write toggles, required 101", we_seen - we_base);
    end
    check("pre_rst_active", 64'({sd_ack, busy, mem_we_req}), 64'h7);
    #1;
    RESET_N = 1'b0;
    #1;
    check("mid_rst_ack_busy", 64'({sd_ack, busy}), 64'd0);
    check("mid_rst_toggles", 64'({mem_rd_req, mem_we_req}), 64'd0);
    check("mid_rst_buff_addr", 64'(sd_buff_addr), 64'd0);
    exp_buf.delete();
    exp_rd.delete();
    exp_we.delete();
    repeat (3) @(negedge clk_sys);
    RESET_N = 1'b1;
    repeat (2) @(negedge clk_sys);
    do_xfer(1'b1, 1'b0, 1'b0, 32'd9);

    repeat (5) @(negedge clk_sys);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
